// File: rtl/data_memory_master_if.sv
// Bundle of the request/response handshake and the level-sensitive data
// memory port. "master" is the view of the data memory master block itself;
// "slave" is the view of the datapath plus memory surrounding it.
interface data_memory_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_ren, mem_wen, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/data_memory_master.sv
// Data memory initiator: turns load/store requests into setup/strobe/hold
// sequences on an asynchronous-read, level-write memory. Sub-word stores are
// done as read-modify-write; sub-word loads are lane-extracted and extended.
module data_memory_master #(
    parameter int ADDR_WORD_BITS = 12,
    parameter int STROBE_CYCLES  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    data_memory_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RESP, ERR
    } state_t;

    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        write_r;
    logic        signed_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;
    logic        ready_r;
    logic        resp_valid_r;
    logic        resp_error_r;
    logic [31:0] resp_rdata_r;
    logic        mem_ren_r;
    logic        mem_wen_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_din_r;
    logic        range_err_s;
    logic        align_err_s;
    logic        req_error_s;

    // Little-endian lane extraction with sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   load_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane of the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] w;
        w = word;
        case (size)
            2'b00: w[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) begin
                    w[31:16] = wd;
                end else begin
                    w[15:0] = wd;
                end
            end
            default: w = word;
        endcase
        store_merge = w;
    endfunction

    // Request legality: illegal size, misalignment, or address beyond the memory.
    always_comb begin
        range_err_s = |bus.req_addr[31:ADDR_WORD_BITS+2];
        align_err_s = 1'b0;
        case (bus.req_size)
            2'b00:   align_err_s = 1'b0;
            2'b01:   align_err_s = bus.req_addr[0];
            2'b10:   align_err_s = |bus.req_addr[1:0];
            default: align_err_s = 1'b1;
        endcase
        req_error_s = range_err_s | align_err_s;
    end

    // Access sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            write_r      <= 1'b0;
            signed_r     <= 1'b0;
            size_r       <= 2'b00;
            lane_r       <= 2'b00;
            wdata_r      <= 16'd0;
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_ren_r    <= 1'b0;
            mem_wen_r    <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_din_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ready_r && bus.req_valid) begin
                        ready_r  <= 1'b0;
                        write_r  <= bus.req_write;
                        size_r   <= bus.req_size;
                        signed_r <= bus.req_signed;
                        lane_r   <= bus.req_addr[1:0];
                        wdata_r  <= bus.req_wdata[15:0];
                        if (req_error_s) begin
                            state_r      <= ERR;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                        end else if (bus.req_write && (bus.req_size == 2'b10)) begin
                            state_r    <= WR_SETUP;
                            mem_addr_r <= {2'b00, bus.req_addr[31:2]};
                            mem_din_r  <= bus.req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_r    <= RD_SETUP;
                            mem_addr_r <= {2'b00, bus.req_addr[31:2]};
                        end
                    end else begin
                        // Also covers the first cycle after reset release.
                        ready_r <= 1'b1;
                    end
                end
                RD_SETUP: begin
                    state_r   <= RD_STROBE;
                    mem_ren_r <= 1'b1;
                    cnt_r     <= 8'd0;
                end
                RD_STROBE: begin
                    if (cnt_r == STROBE_LAST) begin
                        mem_ren_r <= 1'b0;
                        if (write_r) begin
                            state_r   <= WR_SETUP;
                            mem_din_r <= store_merge(bus.mem_dout, size_r, lane_r, wdata_r);
                        end else begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_extract(bus.mem_dout, size_r, lane_r, signed_r);
                            mem_addr_r   <= 32'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WR_SETUP: begin
                    state_r   <= WR_STROBE;
                    mem_wen_r <= 1'b1;
                    cnt_r     <= 8'd0;
                end
                WR_STROBE: begin
                    if (cnt_r == STROBE_LAST) begin
                        state_r   <= WR_HOLD;
                        mem_wen_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WR_HOLD: begin
                    state_r      <= RESP;
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= 32'd0;
                    mem_addr_r   <= 32'd0;
                    mem_din_r    <= 32'd0;
                end
                RESP: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                ERR: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    mem_ren_r    <= 1'b0;
                    mem_wen_r    <= 1'b0;
                    mem_addr_r   <= 32'd0;
                    mem_din_r    <= 32'd0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_error = resp_error_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_ren    = mem_ren_r;
    assign bus.mem_wen    = mem_wen_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_din    = mem_din_r;
endmodule

// File: doc/data_memory_master.md
Name: data_memory_master

Overview:
- Initiator for the CPU's level-sensitive data memory port (ren/wen/addr/din/dout, word-indexed, asynchronous read, write occurs while wen is high).
- Accepts load/store requests from the datapath over a valid/ready handshake and sequences the memory strobes safely: setup, strobe, hold.
- Converts byte addresses to word indices and performs byte/halfword load extraction with sign or zero extension.
- Implements sub-word stores (sb/sh) as read-modify-write.

Parameters:
- ADDR_WORD_BITS, 12: word-index width of the attached memory; valid byte addresses are below 2^(ADDR_WORD_BITS+2).
- STROBE_CYCLES, 1: cycles that mem_ren or mem_wen stays high per access (>=1).

Ports:
- clock  in  1  system clock, posedge active
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- resp_error  out  1  valid with resp_valid; misaligned, out-of-range or illegal size
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_addr  out  32  word index = req_addr >> 2
- mem_din  out  32  memory write data
- mem_dout  in  32  memory read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While reset=0, every output is 0 and the FSM is IDLE.
  - This applies mid-operation: mem_wen and mem_ren drop in the same instant reset falls.
  - No response is produced for an aborted request.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - A request is accepted on a posedge with req_valid && req_ready.
  - All request fields are registered on acceptance; the requester may change them afterwards.
- Error checks at acceptance, giving state ERR with no memory activity:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_WORD_BITS+2]!=0.
- States: IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RESP, ERR.
- Transitions:
  - Load: IDLE -> RD_SETUP -> RD_STROBE (STROBE_CYCLES cycles) -> RESP -> IDLE.
  - Word store: IDLE -> WR_SETUP -> WR_STROBE (STROBE_CYCLES) -> WR_HOLD -> RESP -> IDLE.
  - Sub-word store: IDLE -> RD_SETUP -> RD_STROBE -> WR_SETUP -> WR_STROBE -> WR_HOLD -> RESP -> IDLE.
  - Error: IDLE -> ERR -> IDLE.
- Outputs per state:
  - mem_ren=1 only in RD_STROBE; mem_wen=1 only in WR_STROBE. They are registered and never both high.
  - mem_addr is driven from RD_SETUP through WR_HOLD and is constant across that span. It is 0 in IDLE, RESP and ERR.
  - mem_din is valid and constant from WR_SETUP through WR_HOLD, so addr and din are stable one full cycle before wen rises and one full cycle after it falls.
  - resp_valid=1 for exactly one cycle, in RESP or in ERR (with resp_error=1).
- Read capture: mem_dout is sampled on the posedge that ends the last RD_STROBE cycle.
- Latency with STROBE_CYCLES=1, counted in cycles from the accept edge to resp_valid high:
  - load: 3
  - word store: 4
  - sub-word store: 6
  - error: 1
  - Each extra strobe cycle adds 1 per strobe phase.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; lane 0 = bits 7:0. Half lane = addr[1]; lane 0 = bits 15:0.
  - Loads: extract the lane, then extend per req_signed. Word loads ignore req_signed.
  - Sub-word store merge: replace only the addressed lane of the captured word with req_wdata[7:0] or req_wdata[15:0]. All other bits are preserved.
- req_valid held in non-IDLE states is ignored; it is accepted only after returning to IDLE, i.e. at the earliest 1 cycle after RESP or ERR.

Test Plan:
- Word store then load: sw 0x11223344 to 0x4, then lw 0x4.
  - Store: mem_addr=1, wen high for 1 cycle, resp_valid 4 cycles after the store accept edge.
  - Load: resp_rdata=0x11223344, resp_valid 3 cycles after the load accept edge.
- Byte store read-modify-write: starting from the above, sb 0xAA to 0x5.
  - One ren strobe, then one wen strobe, with mem_din=0x1122AA44.
  - resp_valid 6 cycles after accept; a following lw 0x4 returns 0x1122AA44.
- Sub-word loads:
  - lb 0x5 -> 0xFFFFFFAA; lbu 0x5 -> 0x000000AA.
  - lh 0x6 -> 0x00001122 (signed or unsigned).
- Errors:
  - lw 0x6, sh 0x3, size=11, and lw 0x4000 each give resp_valid with resp_error=1 one cycle after accept, and resp_rdata=0.
  - mem_ren and mem_wen never rise.
- Reset mid-write: assert reset during WR_STROBE.
  - mem_wen drops asynchronously and no resp_valid occurs.
  - After release, req_ready=1 and the next lw works normally.
- Protocol assertions with STROBE_CYCLES=3 over random back-to-back requests:
  - ren&&wen never both high.
  - mem_addr and mem_din unchanged from one cycle before wen rises to one cycle after it falls.
  - Strobe width is exactly 3 cycles.
